pipeline_hazard_ctrl: RTL

Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. Generates per-stage en/flush from load-use hazards, taken branches resolved in EX, and a multi-cycle data-memory handshake in MEM. Includes a wait-timeout watchdog that halts the pipeline on a hung memory. Pipeline registers clear on flush at the clock edge regardless of en.

---
 rtl/pipeline_hazard_ctrl_if.sv | 52 +++++
 rtl/pipeline_hazard_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard inputs from the pipeline stages, per-stage
// enables/flushes, the data-memory handshake and status back to the pipeline.
// master = pipeline/datapath side, slave = pipeline_hazard_ctrl.
interface pipeline_hazard_ctrl_if;
    // ID-stage operand usage
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    // EX-stage load / branch information
    logic        ex_dmemread;
    logic [4:0]  ex_regwtaddr;
    logic        ex_branch_taken;
    // MEM-stage access and memory handshake
    logic        mem_dmemread;
    logic        mem_dmemwrite;
    logic        dmem_ack;
    logic        dmem_req;
    // PC and pipeline-register controls
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_en;
    logic        idex_flush;
    logic        exmem_en;
    logic        exmem_flush;
    logic        memwb_en;
    logic        memwb_flush;
    // Status
    logic        dmem_err;
    logic [31:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt,
        output ex_dmemread, ex_regwtaddr, ex_branch_taken,
        output mem_dmemread, mem_dmemwrite, dmem_ack,
        input  dmem_req, pc_en,
        input  ifid_en, ifid_flush, idex_en, idex_flush,
        input  exmem_en, exmem_flush, memwb_en, memwb_flush,
        input  dmem_err, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  ex_dmemread, ex_regwtaddr, ex_branch_taken,
        input  mem_dmemread, mem_dmemwrite, dmem_ack,
        output dmem_req, pc_en,
        output ifid_en, ifid_flush, idex_en, idex_flush,
        output exmem_en, exmem_flush, memwb_en, memwb_flush,
        output dmem_err, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the 5-stage pipeline: PC / pipeline-register enables
// and flushes from load-use hazards, taken branches resolved in EX and a
// multi-cycle data-memory handshake in MEM, with a wait-timeout watchdog that
// halts the pipeline on a hung memory (sticky dmem_err, cleared by reset only).
// Controls are combinational from state + inputs (zero latency).
// Optional: define PERF_STALL_CNT_EN to build the stall_cycles counter;
// otherwise stall_cycles is tied to 0.
module pipeline_hazard_ctrl #(
    parameter int unsigned TO_CYCLES = 64,
    parameter int unsigned TO_W      = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] HALT     = 2'd2;

    localparam int unsigned REG_W = 5;

    logic [1:0]      state;
    logic [1:0]      stateNext;
    logic [TO_W-1:0] waitCnt;
    logic [TO_W-1:0] waitCntNext;
    logic            dmemErr;
    logic            dmemErrNext;

    logic            memAcc;
    logic            rsHit;
    logic            rtHit;
    logic            loadUse;
    logic            memStall;
    logic            halted;

    logic            dmemReq;
    logic            pcEn;
    logic            ifidEn;
    logic            ifidFlush;
    logic            idexEn;
    logic            idexFlush;
    logic            exmemEn;
    logic            exmemFlush;
    logic            memwbEn;
    logic            memwbFlush;

    // Hazard detection: MEM access request and load-use against the EX load
    always_comb begin
        memAcc  = hz.mem_dmemread | hz.mem_dmemwrite;
        rsHit   = hz.id_uses_rs && (hz.id_rs == hz.ex_regwtaddr);
        rtHit   = hz.id_uses_rt && (hz.id_rt == hz.ex_regwtaddr);
        loadUse = hz.ex_dmemread
                  && (hz.ex_regwtaddr != REG_W'(0))
                  && (rsHit || rtHit);
    end

    // State, wait counter and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            waitCnt <= '0;
            dmemErr <= 1'b0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            dmemErr <= dmemErrNext;
        end
    end

    // Next-state logic and stage controls; memory stall masks branch/load-use
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        dmemErrNext = dmemErr;
        memStall    = 1'b0;
        halted      = 1'b0;
        dmemReq     = 1'b0;
        pcEn        = 1'b1;
        ifidEn      = 1'b1;
        ifidFlush   = 1'b0;
        idexEn      = 1'b1;
        idexFlush   = 1'b0;
        exmemEn     = 1'b1;
        exmemFlush  = 1'b0;
        memwbEn     = 1'b1;
        memwbFlush  = 1'b0;

        case (state)
            RUN: begin
                dmemReq = memAcc;
                if (memAcc && !hz.dmem_ack) begin
                    memStall    = 1'b1;
                    stateNext   = MEM_WAIT;
                    waitCntNext = TO_W'(1);
                end
            end
            MEM_WAIT: begin
                // request held for the whole outstanding access
                dmemReq = 1'b1;
                if (hz.dmem_ack) begin
                    stateNext   = RUN;
                    waitCntNext = '0;
                end else begin
                    memStall = 1'b1;
                    if (waitCnt == TO_W'(TO_CYCLES)) begin
                        stateNext   = HALT;
                        dmemErrNext = 1'b1;
                    end else begin
                        waitCntNext = waitCnt + TO_W'(1);
                    end
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                stateNext   = RUN;
                waitCntNext = '0;
            end
        endcase

        if (halted) begin
            // frozen until reset, no flushes so state stays inspectable
            pcEn    = 1'b0;
            ifidEn  = 1'b0;
            idexEn  = 1'b0;
            exmemEn = 1'b0;
            memwbEn = 1'b0;
        end else if (memStall) begin
            // hold everything upstream of MEM, push a bubble into WB
            pcEn       = 1'b0;
            ifidEn     = 1'b0;
            idexEn     = 1'b0;
            exmemEn    = 1'b0;
            memwbFlush = 1'b1;
        end else if (hz.ex_branch_taken) begin
            // ID/IF hold wrong-path instructions; this also cancels load-use
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else if (loadUse) begin
            // one bubble: hold PC and IF/ID, clear ID/EX
            pcEn      = 1'b0;
            ifidEn    = 1'b0;
            idexFlush = 1'b1;
        end

        if (rst) begin
            dmemReq    = 1'b0;
            pcEn       = 1'b0;
            ifidEn     = 1'b0;
            ifidFlush  = 1'b1;
            idexEn     = 1'b0;
            idexFlush  = 1'b1;
            exmemEn    = 1'b0;
            exmemFlush = 1'b1;
            memwbEn    = 1'b0;
            memwbFlush = 1'b1;
        end
    end

    assign hz.dmem_req    = dmemReq;
    assign hz.pc_en       = pcEn;
    assign hz.ifid_en     = ifidEn;
    assign hz.ifid_flush  = ifidFlush;
    assign hz.idex_en     = idexEn;
    assign hz.idex_flush  = idexFlush;
    assign hz.exmem_en    = exmemEn;
    assign hz.exmem_flush = exmemFlush;
    assign hz.memwb_en    = memwbEn;
    assign hz.memwb_flush = memwbFlush;
    assign hz.dmem_err    = dmemErr;

`ifdef PERF_STALL_CNT_EN
    logic [31:0] stallCnt;

    // Count cycles with the PC held (memory stall or load-use), wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt <= '0;
        end else if (!pcEn && (state != HALT)) begin
            stallCnt <= stallCnt + 32'd1;
        end
    end

    assign hz.stall_cycles = stallCnt;
`else
    assign hz.stall_cycles = 32'd0;
`endif

    // Structural invariants of the control outputs
    a_exmem_flush_rst_only : assert property (@(posedge clk) disable iff (rst)
        !hz.exmem_flush);
    a_halt_quiet : assert property (@(posedge clk) disable iff (rst)
        (state == HALT) |-> (!hz.dmem_req && !hz.pc_en && !hz.memwb_flush));
    a_halt_sticky_err : assert property (@(posedge clk) disable iff (rst)
        (state == HALT) |-> dmemErr);
    a_stall_holds_pc : assert property (@(posedge clk) disable iff (rst)
        memStall |-> (!hz.pc_en && !hz.ifid_flush && !hz.idex_flush));

endmodule
